// File: rtl/sample_fifo_writer_if.sv
// Byte-wide write port into the SPI tx FIFO.
// The writer drives the strobe and data; the FIFO returns its full flag.
interface sample_fifo_writer_if;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       fifo_full;

  modport master (output fifo_wr_en, output fifo_wr_data, input fifo_full);
  modport slave  (input fifo_wr_en, input fifo_wr_data, output fifo_full);
endinterface

// File: rtl/sample_fifo_writer.sv
// Buffers one reduced sample and writes each 24-bit frame to the tx FIFO as 3 bytes, LSB first,
// with a periodic sync-marker frame inserted for host resync. Overrun samples are dropped and counted.
module sample_fifo_writer #(
  parameter int unsigned          DATA_SIZE   = 24,
  parameter int unsigned          SYNC_PERIOD = 126,
  parameter logic [DATA_SIZE-1:0] SYNC_WORD   = 24'hAAFF00,
  parameter int unsigned          DROP_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sample_valid,
  input  logic [DATA_SIZE-1:0]    sample_data,
  sample_fifo_writer_if.master    fifo,
  output logic                    busy,
  output logic                    marker_pulse,
  output logic [DROP_W-1:0]       drop_count
);

  localparam int unsigned      CNT_W    = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_PERIOD - 1);
  localparam bit               SYNC_EN  = (SYNC_PERIOD != 0);

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, BYTE2} state_t;

  state_t                 state;
  logic                   slot_vld_p0;
  logic [DATA_SIZE-1:0]   slot_data_p0;
  logic [DATA_SIZE-1:0]   frame_p1;
  logic                   marker_pending;
  logic [CNT_W-1:0]       frame_cnt;
  logic                   accept;
  logic                   take_marker;
  logic                   take_slot;
  logic                   slot_load;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [DATA_SIZE-1:0] f, input state_t s);
    case (s)
      BYTE1:   return f[15:8];
      BYTE2:   return f[23:16];
      default: return f[7:0];
    endcase
  endfunction

  // A pending marker always wins the IDLE slot, so the slot waits one extra frame.
  assign accept      = enable && sample_valid;
  assign take_marker = (state == IDLE) && marker_pending;
  assign take_slot   = (state == IDLE) && !marker_pending && slot_vld_p0;
  assign slot_load   = accept && (!slot_vld_p0 || take_slot);
  assign busy        = (state != IDLE) || slot_vld_p0 || marker_pending;

  // Stage 0: single-entry sample slot and overrun counter
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_p0 <= 1'b0;
      drop_count  <= '0;
    end else if (accept) begin
      if (slot_load) slot_vld_p0 <= 1'b1;
      else           drop_count  <= sat_inc(drop_count);
    end else if (take_slot) begin
      slot_vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (slot_load) slot_data_p0 <= sample_data;
  end

  // Stage 1: frame being serialised
  always_ff @(posedge clk) begin
    if (take_marker)    frame_p1 <= SYNC_WORD;
    else if (take_slot) frame_p1 <= slot_data_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      marker_pending    <= 1'b0;
      frame_cnt         <= '0;
      marker_pulse      <= 1'b0;
      fifo.fifo_wr_en   <= 1'b0;
      fifo.fifo_wr_data <= '0;
    end else begin
      marker_pulse    <= 1'b0;
      fifo.fifo_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (take_marker) begin
            marker_pending <= 1'b0;
            marker_pulse   <= 1'b1;
            state          <= BYTE0;
          end else if (take_slot) begin
            state <= BYTE0;
            // Only sample frames advance the period; a wrap while a marker is pending does not stack.
            if (SYNC_EN) begin
              if (frame_cnt == CNT_LAST) begin
                frame_cnt      <= '0;
                marker_pending <= 1'b1;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          if (!fifo.fifo_full) begin
            fifo.fifo_wr_en   <= 1'b1;
            fifo.fifo_wr_data <= frame_byte(frame_p1, state);
            case (state)
              BYTE0:   state <= BYTE1;
              BYTE1:   state <= BYTE2;
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_fifo_writer.sv
// Directed scenarios plus randomized traffic checked cycle by cycle against a queue-based model.
module tb_sample_fifo_writer;
  localparam int SP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sample_valid;
  logic [23:0] sample_data;
  logic        busy;
  logic        marker_pulse;
  logic [15:0] drop_count;

  sample_fifo_writer_if fif ();

  sample_fifo_writer #(
    .DATA_SIZE   (24),
    .SYNC_PERIOD (SP),
    .SYNC_WORD   (24'hAAFF00),
    .DROP_W      (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .fifo         (fif.master),
    .busy         (busy),
    .marker_pulse (marker_pulse),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes of the frame in flight, the held sample, the marker flag.
  logic [7:0]  mq[$];
  bit          m_slot_v;
  logic [23:0] m_slot;
  bit          m_mk;
  int          m_frames;
  int          m_drop;
  bit          exp_wr;
  logic [7:0]  exp_data;
  bit          exp_pulse;
  bit          m_rst_edge;

  logic [7:0]  seen[$];
  int          seen_edge[$];
  int          edge_n = 0;
  int          pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [23:0] f);
    mq.push_back(f[7:0]);
    mq.push_back(f[15:8]);
    mq.push_back(f[23:16]);
  endtask

  task automatic model_edge();
    exp_wr     = 1'b0;
    exp_pulse  = 1'b0;
    m_rst_edge = 1'b0;
    if (rst) begin
      mq.delete();
      m_slot_v   = 1'b0;
      m_mk       = 1'b0;
      m_frames   = 0;
      m_drop     = 0;
      m_rst_edge = 1'b1;
      exp_data   = 8'h00;
    end else begin
      if (mq.size() == 0) begin
        if (m_mk) begin
          push_frame(24'hAAFF00);
          m_mk      = 1'b0;
          exp_pulse = 1'b1;
        end else if (m_slot_v) begin
          push_frame(m_slot);
          m_slot_v = 1'b0;
          m_frames++;
          if (m_frames % SP == 0) m_mk = 1'b1;
        end
      end else if (!fif.fifo_full) begin
        exp_wr   = 1'b1;
        exp_data = mq.pop_front();
      end
      if (enable && sample_valid) begin
        if (m_slot_v) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          m_slot   = sample_data;
          m_slot_v = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check("wr_en", fif.fifo_wr_en, exp_wr);
    if (exp_wr || m_rst_edge) check("wr_data", fif.fifo_wr_data, exp_data);
    check("busy", busy, (mq.size() != 0) || m_slot_v || m_mk);
    check("marker_pulse", marker_pulse, exp_pulse);
    check("drop_count", drop_count, m_drop);
    if (fif.fifo_wr_en) begin
      seen.push_back(fif.fifo_wr_data);
      seen_edge.push_back(edge_n);
    end
    if (marker_pulse) pulses++;
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [23:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    seen.delete();
    seen_edge.delete();
    pulses = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [7:0] exp4[18];
    rst            = 1'b1;
    enable         = 1'b1;
    sample_valid   = 1'b0;
    sample_data    = '0;
    fif.fifo_full  = 1'b0;

    // 1: basic latency and byte order
    do_reset();
    check("rst_drop", drop_count, 0);
    check("rst_busy", busy, 0);
    send(24'h123456);
    e0 = edge_n;
    idle(6);
    check("t1_nbytes", seen.size(), 3);
    if (seen.size() == 3) begin
      check("t1_b0", seen[0], 8'h56);
      check("t1_b1", seen[1], 8'h34);
      check("t1_b2", seen[2], 8'h12);
      check("t1_latency", seen_edge[0] - e0, 2);
      check("t1_back2back", seen_edge[2] - seen_edge[0], 2);
    end

    // 2: FIFO full stall during BYTE1
    do_reset();
    send(24'h123456);
    idle(2);
    fif.fifo_full = 1'b1;
    idle(10);
    fif.fifo_full = 1'b0;
    idle(6);
    check("t2_nbytes", seen.size(), 3);
    if (seen.size() == 3) begin
      check("t2_b0", seen[0], 8'h56);
      check("t2_b1", seen[1], 8'h34);
      check("t2_b2", seen[2], 8'h12);
      check("t2_stall", seen_edge[1] - seen_edge[0] >= 11, 1);
    end

    // 3: overrun with three back-to-back samples
    do_reset();
    sample_valid = 1'b1;
    sample_data  = 24'h0A0B0C; step();
    sample_data  = 24'h1A1B1C; step();
    sample_data  = 24'h2A2B2C; step();
    idle(16);
    check("t3_drop", drop_count, 1);
    check("t3_nbytes_ge6", seen.size() >= 6, 1);
    if (seen.size() >= 6) begin
      check("t3_a0", seen[0], 8'h0C);
      check("t3_b0", seen[3], 8'h1C);
      check("t3_b2", seen[5], 8'h1A);
    end

    // 4: marker insertion every SP sample frames
    do_reset();
    send(24'h010203); idle(8);
    send(24'h111213); idle(8);
    send(24'h212223); idle(8);
    send(24'h313233); idle(12);
    exp4 = '{8'h03, 8'h02, 8'h01, 8'h13, 8'h12, 8'h11, 8'h00, 8'hFF, 8'hAA,
             8'h23, 8'h22, 8'h21, 8'h33, 8'h32, 8'h31, 8'h00, 8'hFF, 8'hAA};
    check("t4_nbytes", seen.size(), 18);
    if (seen.size() == 18)
      for (int i = 0; i < 18; i++) check($sformatf("t4_byte%0d", i), seen[i], exp4[i]);
    check("t4_pulses", pulses, 2);

    // 5: reset during BYTE1 aborts the frame
    do_reset();
    send(24'h445566);
    idle(2);
    rst = 1'b1;
    idle(1);
    check("t5_wr_en", fif.fifo_wr_en, 0);
    check("t5_busy", busy, 0);
    check("t5_drop", drop_count, 0);
    rst = 1'b0;
    idle(2);
    seen.delete();
    seen_edge.delete();
    send(24'h778899);
    e0 = edge_n;
    idle(6);
    check("t5_nbytes", seen.size(), 3);
    if (seen.size() == 3) begin
      check("t5_b0", seen[0], 8'h99);
      check("t5_latency", seen_edge[0] - e0, 2);
    end

    // 6: enable low ignores samples but finishes the frame in flight
    do_reset();
    send(24'hCAFE01);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(24'($urandom));
      idle(1);
    end
    idle(4);
    check("t6_nbytes", seen.size(), 3);
    if (seen.size() == 3) check("t6_b2", seen[2], 8'hCA);
    check("t6_drop", drop_count, 0);
    enable = 1'b1;

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      enable        = ($urandom_range(0, 9) != 0);
      sample_valid  = ($urandom_range(0, 2) == 0);
      sample_data   = 24'($urandom);
      fif.fifo_full = ($urandom_range(0, 3) == 0);
      step();
    end
    rst           = 1'b0;
    fif.fifo_full = 1'b0;
    idle(20);
    check("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
